// File: rtl/hcms_frame_feeder.sv
// Frame sequencer for the HCMS-29xx shifter: holds an ASCII buffer and streams
// reset / control words / font columns as bytes over a load/ready handshake.
module hcms_frame_feeder #(
  parameter int          NUM_CHARS    = 8,
  parameter logic [7:0]  CW0          = 8'b0100_1111,
  parameter logic [7:0]  CW1          = 8'b1000_0001,
  parameter int          RESET_CYCLES = 16
) (
  input  logic       i_CLK,
  input  logic       i_RST,
  input  logic       i_wr_en,
  input  logic [3:0] i_wr_addr,
  input  logic [7:0] i_wr_char,
  input  logic       i_frame_start,
  output logic       o_busy,
  output logic       o_frame_done,
  output logic [6:0] o_font_char,
  output logic [2:0] o_font_col,
  input  logic [7:0] i_font_data,
  output logic [7:0] o_data,
  output logic       o_cmd,
  output logic       o_data_load,
  input  logic       i_ready,
  output logic       o_hcms_reset
);

  localparam int IW  = (NUM_CHARS > 1) ? $clog2(NUM_CHARS) : 1;
  localparam int RCW = $clog2(RESET_CYCLES + 1);

  typedef enum logic [3:0] {
    S_IDLE, S_RST_HOLD, S_CW0, S_CW1, S_FETCH, S_WAIT_FONT, S_XFER, S_RELEASE, S_DONE
  } state_t;

  // Which byte is in flight, so the shared XFER/RELEASE path knows where to return.
  typedef enum logic [1:0] {K_CW0, K_CW1, K_DATA} kind_t;

  state_t         state, next_state;
  kind_t          kind;
  logic [7:0]     buffer [0:(1<<IW)-1];
  logic [IW-1:0]  char_idx;
  logic [2:0]     col;
  logic [RCW-1:0] rst_cnt;
  logic           init_done;
  logic           pending;
  logic           accept;
  logic           last_byte;
  logic           wr_ok;

  function automatic logic [6:0] glyph(input logic [7:0] code);
    return (code >= 8'h20 && code <= 8'h7E) ? 7'(code - 8'h20) : 7'd0;
  endfunction

  assign accept    = (state == S_IDLE) && (i_frame_start || pending);
  assign last_byte = (col == 3'd4) && (char_idx == '0);
  assign wr_ok     = i_wr_en && (int'(i_wr_addr) < NUM_CHARS);

  // Address follows the live buffer, so late writes reach not-yet-fetched characters.
  assign o_font_char  = glyph(buffer[char_idx]);
  assign o_font_col   = col;
  assign o_data_load  = (state == S_XFER);
  assign o_hcms_reset = (state == S_RST_HOLD);
  assign o_frame_done = (state == S_DONE);
  assign o_busy       = (state != S_IDLE) && (state != S_DONE);

  always_comb begin
    // NOTE: default assigned first so every path drives next_state and no latch is inferred.
    next_state = state;
    case (state)
      S_IDLE:      if (accept) next_state = init_done ? S_FETCH : S_RST_HOLD;
      S_RST_HOLD:  if (rst_cnt == RCW'(RESET_CYCLES - 1)) next_state = S_CW0;
      S_CW0,
      S_CW1:       next_state = S_XFER;
      S_FETCH:     next_state = S_WAIT_FONT;
      S_WAIT_FONT: next_state = S_XFER;
      S_XFER:      if (i_ready) next_state = S_RELEASE;
      S_RELEASE: begin
        if (!i_ready) begin
          case (kind)
            K_CW0:   next_state = S_CW1;
            K_CW1:   next_state = S_FETCH;
            default: next_state = last_byte ? S_DONE : S_FETCH;
          endcase
        end
      end
      S_DONE:      next_state = S_IDLE;
      default:     next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge i_CLK) begin
    if (i_RST) begin
      state     <= S_IDLE;
      kind      <= K_CW0;
      char_idx  <= '0;
      col       <= '0;
      rst_cnt   <= '0;
      init_done <= 1'b0;
      pending   <= 1'b0;
      o_data    <= '0;
      o_cmd     <= 1'b0;
      // NOTE: the buffer is a small register file that must read as blanks after reset,
      // so it is cleared explicitly here rather than mapped to a RAM macro.
      for (int i = 0; i < (1 << IW); i++) buffer[i] <= 8'h20;
    end else begin
      state <= next_state;

      if (wr_ok) buffer[i_wr_addr[IW-1:0]] <= i_wr_char;

      if (accept)
        pending <= 1'b0;
      else if (state != S_IDLE && i_frame_start)
        pending <= 1'b1;

      case (state)
        S_IDLE: begin
          rst_cnt <= '0;
          if (accept) begin
            char_idx <= IW'(NUM_CHARS - 1);
            col      <= '0;
          end
        end
        S_RST_HOLD: rst_cnt <= rst_cnt + 1'b1;
        S_CW0: begin
          o_data <= CW0;
          o_cmd  <= 1'b1;
          kind   <= K_CW0;
        end
        S_CW1: begin
          o_data <= CW1;
          o_cmd  <= 1'b1;
          kind   <= K_CW1;
        end
        S_WAIT_FONT: begin
          o_data <= i_font_data;
          o_cmd  <= 1'b0;
          kind   <= K_DATA;
        end
        S_RELEASE: begin
          if (!i_ready) begin
            if (kind == K_CW1) init_done <= 1'b1;
            if (kind == K_DATA) begin
              if (col == 3'd4) begin
                col <= '0;
                if (char_idx != '0) char_idx <= char_idx - 1'b1;
              end else begin
                col <= col + 3'd1;
              end
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_hcms_frame_feeder.sv
// Randomised bench for hcms_frame_feeder: shifter and font ROM models, plus a
// reference model that predicts every byte of each frame from the buffer contents.
`timescale 1ns/1ps
module tb_hcms_frame_feeder;

  localparam int N = 8;

  logic       i_CLK = 1'b0;
  logic       i_RST = 1'b1;
  logic       i_wr_en = 1'b0;
  logic [3:0] i_wr_addr = '0;
  logic [7:0] i_wr_char = '0;
  logic       i_frame_start = 1'b0;
  logic [7:0] i_font_data;
  logic       i_ready;
  logic       o_busy, o_frame_done, o_cmd, o_data_load, o_hcms_reset;
  logic [6:0] o_font_char;
  logic [2:0] o_font_col;
  logic [7:0] o_data;

  hcms_frame_feeder #(.NUM_CHARS(N)) dut (
    .i_CLK(i_CLK), .i_RST(i_RST), .i_wr_en(i_wr_en), .i_wr_addr(i_wr_addr),
    .i_wr_char(i_wr_char), .i_frame_start(i_frame_start), .o_busy(o_busy),
    .o_frame_done(o_frame_done), .o_font_char(o_font_char), .o_font_col(o_font_col),
    .i_font_data(i_font_data), .o_data(o_data), .o_cmd(o_cmd),
    .o_data_load(o_data_load), .i_ready(i_ready), .o_hcms_reset(o_hcms_reset)
  );

  always #5 i_CLK = ~i_CLK;

  int errors = 0;
  int checks = 0;

  // Reference model state
  logic [7:0] mbuf [N];
  bit         m_init;
  logic [8:0] exp_q[$];

  // Monitor observations
  logic [8:0] got[$];
  int rst_hi, rst_pulses, done_cnt, unstable, early_load, gap, min_gap;

  // Shifter model knobs
  int ready_lat  = 10;
  int ready_hold = 0;

  function automatic logic [6:0] glyph(input logic [7:0] c);
    return (c >= 8'h20 && c <= 8'h7E) ? 7'(c - 8'h20) : 7'd0;
  endfunction

  // Synthetic font: column byte built from glyph index and column number.
  function automatic logic [7:0] font_byte(input logic [6:0] g, input logic [2:0] c);
    return {g[4:0], c} ^ {g[6:5], 6'b0};
  endfunction

  // Font ROM, one cycle of read latency
  initial begin
    i_font_data = '0;
    forever begin
      @(posedge i_CLK);
      i_font_data <= font_byte(o_font_char, o_font_col);
    end
  end

  // Shifter: raises ready ready_lat cycles into a load, drops it ready_hold cycles after load falls.
  initial begin
    int lat_cnt;
    int hold_cnt;
    lat_cnt  = 0;
    hold_cnt = 0;
    i_ready  = 1'b0;
    forever begin
      @(negedge i_CLK);
      if (o_data_load && !i_ready) begin
        if (lat_cnt >= ready_lat - 1) begin i_ready = 1'b1; lat_cnt = 0; end
        else lat_cnt++;
      end else if (i_ready && !o_data_load) begin
        if (hold_cnt >= ready_hold) begin i_ready = 1'b0; hold_cnt = 0; end
        else hold_cnt++;
      end else if (!o_data_load && !i_ready) begin
        lat_cnt = 0;
      end
    end
  end

  // Monitor, sampling just after each rising edge
  initial begin
    logic       ld_q;
    logic       hr_q;
    logic [8:0] last;
    ld_q = 1'b0; hr_q = 1'b0; last = '0; gap = 0;
    forever begin
      @(posedge i_CLK); #1;
      if (o_data_load && !ld_q) begin
        got.push_back({o_cmd, o_data});
        last = {o_cmd, o_data};
        if (i_ready) early_load++;
        if (gap < min_gap) min_gap = gap;
      end else if (o_data_load && ({o_cmd, o_data} !== last)) begin
        unstable++;
      end
      gap = o_data_load ? 0 : gap + 1;
      if (o_hcms_reset) rst_hi++;
      if (o_hcms_reset && !hr_q) rst_pulses++;
      if (o_frame_done) done_cnt++;
      ld_q = o_data_load;
      hr_q = o_hcms_reset;
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic clear_mon();
    got.delete();
    rst_hi = 0; rst_pulses = 0; done_cnt = 0;
    unstable = 0; early_load = 0; min_gap = 1_000_000;
  endtask

  task automatic model_reset();
    for (int i = 0; i < N; i++) mbuf[i] = 8'h20;
    m_init = 1'b0;
  endtask

  // Appends one frame's worth of expected bytes: highest char first, columns 0..4.
  task automatic push_frame();
    if (!m_init) begin
      exp_q.push_back({1'b1, 8'h4F});
      exp_q.push_back({1'b1, 8'h81});
      m_init = 1'b1;
    end
    for (int i = N - 1; i >= 0; i--)
      for (int c = 0; c < 5; c++)
        exp_q.push_back({1'b0, font_byte(glyph(mbuf[i]), 3'(c))});
  endtask

  task automatic write_char(input logic [3:0] addr, input logic [7:0] ch);
    @(negedge i_CLK);
    i_wr_en = 1'b1; i_wr_addr = addr; i_wr_char = ch;
    @(negedge i_CLK);
    i_wr_en = 1'b0;
    if (int'(addr) < N) mbuf[addr] = ch;
  endtask

  task automatic compare_bytes(input string name);
    checks++;
    if (got.size() !== exp_q.size()) begin
      errors++;
      $display("FAIL %s byte_count: got %0d expected %0d", name, got.size(), exp_q.size());
    end
    for (int i = 0; i < got.size() && i < exp_q.size(); i++) begin
      checks++;
      if (got[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL %s byte[%0d]: got cmd=%0b data=%02h expected cmd=%0b data=%02h",
                 name, i, got[i][8], got[i][7:0], exp_q[i][8], exp_q[i][7:0]);
      end
    end
  endtask

  // Requests a frame, optionally pulses extra requests mid-frame, waits, checks everything.
  task automatic run_frame(input string name, input int extra_starts, input int frames,
                           input int resets);
    int t;
    clear_mon();
    @(negedge i_CLK);
    i_frame_start = 1'b1;
    @(posedge i_CLK); #1;
    checks++;
    if (o_busy !== 1'b1) begin
      errors++;
      $display("FAIL %s busy_after_start: got %0b expected 1", name, o_busy);
    end
    @(negedge i_CLK);
    i_frame_start = 1'b0;
    for (int k = 0; k < extra_starts; k++) begin
      repeat ($urandom_range(5, 40)) @(negedge i_CLK);
      i_frame_start = 1'b1;
      @(negedge i_CLK);
      i_frame_start = 1'b0;
    end
    t = 0;
    while (done_cnt < frames && t < 20000) begin
      @(posedge i_CLK);
      t++;
    end
    checks++;
    if (done_cnt < frames) begin
      errors++;
      $display("FAIL %s timeout: frames_done %0d expected %0d", name, done_cnt, frames);
    end
    repeat (40) @(negedge i_CLK);
    checks++;
    if (done_cnt !== frames) begin
      errors++;
      $display("FAIL %s done_pulses: got %0d expected %0d", name, done_cnt, frames);
    end
    checks++;
    if (rst_pulses !== resets || rst_hi !== 16 * resets) begin
      errors++;
      $display("FAIL %s hcms_reset: got pulses=%0d cycles=%0d expected pulses=%0d cycles=%0d",
               name, rst_pulses, rst_hi, resets, 16 * resets);
    end
    checks++;
    if (unstable !== 0 || early_load !== 0) begin
      errors++;
      $display("FAIL %s handshake: got unstable=%0d early_load=%0d expected 0 and 0",
               name, unstable, early_load);
    end
    checks++;
    if (o_busy !== 1'b0) begin
      errors++;
      $display("FAIL %s busy_after_done: got %0b expected 0", name, o_busy);
    end
    compare_bytes(name);
  endtask

  task automatic test_reset();
    i_RST = 1'b1;
    repeat (3) @(posedge i_CLK);
    #1;
    checks++;
    if ({o_busy, o_frame_done, o_data_load, o_cmd, o_hcms_reset} !== 5'b0) begin
      errors++;
      $display("FAIL reset_flags: got %05b expected 00000",
               {o_busy, o_frame_done, o_data_load, o_cmd, o_hcms_reset});
    end
    checks++;
    if (o_data !== 8'h00) begin
      errors++;
      $display("FAIL reset_data: got %02h expected 00", o_data);
    end
    checks++;
    if (o_font_char !== 7'd0 || o_font_col !== 3'd0) begin
      errors++;
      $display("FAIL reset_font_addr: got char=%0h col=%0d expected 0 0", o_font_char, o_font_col);
    end
    @(negedge i_CLK);
    i_RST = 1'b0;
    model_reset();
  endtask

  task automatic test_init_frame();
    exp_q.delete();
    push_frame();
    run_frame("init_frame", 0, 1, 1);
  endtask

  task automatic test_hello();
    string s;
    logic [8:0] first_exp;
    s = "HELLO123";
    for (int i = 0; i < N; i++) write_char(4'(i), s[i]);
    exp_q.delete();
    push_frame();
    run_frame("hello", 0, 1, 0);
    first_exp = 9'h098;
    checks++;
    if (got.size() == 0 || got[0] !== first_exp) begin
      errors++;
      $display("FAIL hello_first_byte: got %03h expected %03h",
               (got.size() == 0) ? 9'h1FF : got[0], first_exp);
    end
  endtask

  task automatic test_bad_codes();
    for (int i = 0; i < N; i++) write_char(4'(i), 8'($urandom_range(32, 126)));
    write_char(4'd2, 8'h05);
    write_char(4'd5, 8'h80);
    for (int a = N; a < 16; a++) write_char(4'(a), 8'($urandom_range(32, 126)));
    exp_q.delete();
    push_frame();
    run_frame("bad_codes", 0, 1, 0);
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < N; i++) write_char(4'(i), 8'($urandom_range(0, 255)));
    exp_q.delete();
    push_frame();
    push_frame();
    run_frame("pending", 3, 2, 0);
  endtask

  task automatic test_write_during_frame();
    logic [7:0] new_c;
    new_c = 8'($urandom_range(33, 126));
    for (int i = 0; i < N; i++) write_char(4'(i), 8'($urandom_range(32, 126)));
    mbuf[0] = new_c;
    exp_q.delete();
    push_frame();
    fork
      run_frame("write_during_frame", 0, 1, 0);
      begin
        int t;
        t = 0;
        while (got.size() < 3 && t < 2000) begin
          @(posedge i_CLK);
          t++;
        end
        write_char(4'd0, new_c);
      end
    join
  endtask

  task automatic test_ready_hold();
    ready_hold = 50;
    for (int i = 0; i < N; i++) write_char(4'(i), 8'($urandom_range(32, 126)));
    exp_q.delete();
    push_frame();
    run_frame("ready_hold", 0, 1, 0);
    checks++;
    if (min_gap < 50) begin
      errors++;
      $display("FAIL ready_hold_gap: got min load-low gap %0d expected >= 50", min_gap);
    end
    ready_hold = 0;
    repeat (60) @(negedge i_CLK);
  endtask

  task automatic test_reset_mid_frame();
    int t;
    clear_mon();
    @(negedge i_CLK);
    i_frame_start = 1'b1;
    @(negedge i_CLK);
    i_frame_start = 1'b0;
    t = 0;
    while (got.size() < 10 && t < 5000) begin
      @(negedge i_CLK);
      t++;
    end
    @(negedge i_CLK);
    i_RST = 1'b1;
    @(posedge i_CLK); #1;
    checks++;
    if (o_data_load !== 1'b0 || o_busy !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset_outputs: got load=%0b busy=%0b expected 0 0", o_data_load, o_busy);
    end
    @(negedge i_CLK);
    i_RST = 1'b0;
    model_reset();
    repeat (10) @(negedge i_CLK);
    exp_q.delete();
    push_frame();
    run_frame("after_mid_reset", 0, 1, 1);
  endtask

  initial begin
    clear_mon();
    model_reset();
    test_reset();
    test_init_frame();
    test_hello();
    test_bad_codes();
    test_back_to_back();
    test_write_during_frame();
    test_ready_hold();
    test_reset_mid_frame();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
